// File: rtl/breakpoint_ctrl_pkg.sv
// Shared definitions for the breakpoint controller: FSM state encodings and default counter width.
package breakpoint_ctrl_pkg;

   localparam int unsigned BP_CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      BP_IDLE  = 2'd0,
      BP_ARMED = 2'd1,
      BP_HALT  = 2'd2,
      BP_REARM = 2'd3
   } bp_state_e;

endpackage

// File: rtl/breakpoint_ctrl_match_edge_detect.sv
// Registers the inverted comparator output and flags the rising edge of a match, qualified by
// sample_en, so a static match produces a single event.
module match_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic cmp_neq,
   input  logic sample_en,
   output logic ev,
   output logic match_q
);

   logic prev_match_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_q      <= 1'b0;
         prev_match_q <= 1'b0;
      end else begin
         match_q <= ~cmp_neq;
         // History advances only on qualified samples, so idle cycles never create an edge.
         if (sample_en) begin
            prev_match_q <= match_q;
         end
      end
   end

   assign ev = sample_en & match_q & ~prev_match_q;

endmodule

// File: rtl/breakpoint_ctrl.sv
// Breakpoint controller: skips pass_cnt match events after arming, then requests a debugger halt
// and re-arms once the compared value has left the match.
module breakpoint_ctrl
   import breakpoint_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = BP_CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmp_neq,
   input  logic             sample_en,
   input  logic             arm,
   input  logic             disarm,
   input  logic [CNT_W-1:0] pass_cnt,
   input  logic             halt_ack,
   output logic             halt_req,
   output logic             armed,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic             ev;
   logic             match_q;
   bp_state_e        state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic             halt_req_q, halt_req_d;
   logic             armed_q, armed_d;

   match_edge_detect u_match_edge_detect (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmp_neq   (cmp_neq),
      .sample_en (sample_en),
      .ev        (ev),
      .match_q   (match_q)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      hit_d       = hit_q;

      if (ev && (state_q != BP_IDLE) && (hit_q != CntMax)) begin
         hit_d = hit_q + CntOne;
      end

      if (disarm) begin
         state_d = BP_IDLE;
      end else begin
         unique case (state_q)
            BP_IDLE: begin
               if (arm) begin
                  state_d     = BP_ARMED;
                  remaining_d = pass_cnt;
                  hit_d       = '0;
               end
            end
            BP_ARMED: begin
               if (ev) begin
                  if (remaining_q == '0) begin
                     state_d = BP_HALT;
                  end else begin
                     remaining_d = remaining_q - CntOne;
                  end
               end
            end
            BP_HALT: begin
               if (halt_ack) begin
                  state_d = BP_REARM;
               end
            end
            BP_REARM: begin
               // Wait for a sampled non-match so a held match cannot retrigger the halt.
               if (sample_en && !match_q) begin
                  state_d     = BP_ARMED;
                  remaining_d = pass_cnt;
               end
            end
            default: begin
               state_d = BP_IDLE;
            end
         endcase
      end

      halt_req_d = (state_d == BP_HALT);
      armed_d    = (state_d != BP_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BP_IDLE;
         remaining_q <= '0;
         hit_q       <= '0;
         halt_req_q  <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         hit_q       <= hit_d;
         halt_req_q  <= halt_req_d;
         armed_q     <= armed_d;
      end
   end

   assign halt_req = halt_req_q;
   assign armed    = armed_q;
   assign hit_cnt  = hit_q;

endmodule

// File: tb/tb_breakpoint_ctrl.sv
// Scoreboard bench for breakpoint_ctrl: stimulus queues each expected halt (cycle and hit count),
// a monitor pops and checks it when halt_req rises; quiescent states are checked directly.
module tb_breakpoint_ctrl;

   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmp_neq = 1'b1;
   logic          sample_en = 1'b0;
   logic          arm = 1'b0;
   logic          disarm = 1'b0;
   logic [CW-1:0] pass_cnt = '0;
   logic          halt_ack = 1'b0;
   logic          halt_req;
   logic          armed;
   logic [CW-1:0] hit_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int            tag;
      int            cyc;
      logic [CW-1:0] hit;
   } exp_t;

   exp_t sb_q[$];
   logic halt_prev = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   breakpoint_ctrl #(
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmp_neq   (cmp_neq),
      .sample_en (sample_en),
      .arm       (arm),
      .disarm    (disarm),
      .pass_cnt  (pass_cnt),
      .halt_ack  (halt_ack),
      .halt_req  (halt_req),
      .armed     (armed),
      .hit_cnt   (hit_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: a halt_req rising edge is the DUT presenting a result.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && halt_req && !halt_prev) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_halt: halt_req rose at cycle %0d, expected no halt", cyc);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("halt%0d_cycle", e.tag), cyc, e.cyc);
            chk($sformatf("halt%0d_hit_cnt", e.tag), 32'(hit_cnt), 32'(e.hit));
         end
      end
      halt_prev <= halt_req;
   end

   task automatic step(input logic c, input logic s);
      cmp_neq   = c;
      sample_en = s;
      @(negedge clk);
   endtask

   task automatic expect_halt(input int tag, input int delay, input logic [CW-1:0] hit);
      exp_t e;
      e.tag = tag;
      e.cyc = cyc + delay;
      e.hit = hit;
      sb_q.push_back(e);
   endtask

   // One-sample match: the event lands on the second edge after cmp_neq falls.
   task automatic pulse(input int tag, input bit halts, input logic [CW-1:0] hit);
      if (halts) expect_halt(tag, 2, hit);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
   endtask

   task automatic do_arm(input logic [CW-1:0] pc);
      pass_cnt = pc;
      arm      = 1'b1;
      step(1'b1, 1'b1);
      arm      = 1'b0;
   endtask

   task automatic do_disarm();
      disarm = 1'b1;
      step(1'b1, 1'b1);
      disarm = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_halt_req", 32'(halt_req), 0);
      chk("reset_armed", 32'(armed), 0);
      chk("reset_hit_cnt", 32'(hit_cnt), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // pass_cnt=0: halt on the first match
      do_arm(8'd0);
      chk("t2_armed", 32'(armed), 1);
      pulse(2, 1'b1, 8'd1);
      chk("t2_halt_req", 32'(halt_req), 1);
      chk("t2_hit_cnt", 32'(hit_cnt), 1);

      // Reset mid-HALT with the match still present, then a stale ack
      cmp_neq = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("t1_async_halt_req", 32'(halt_req), 0);
      chk("t1_async_armed", 32'(armed), 0);
      chk("t1_async_hit_cnt", 32'(hit_cnt), 0);
      halt_ack = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("t1_stale_ack_armed", 32'(armed), 0);
      chk("t1_stale_ack_halt_req", 32'(halt_req), 0);
      halt_ack = 1'b0;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);

      // pass_cnt=2: halt on the third separate match; later pass_cnt change is ignored
      do_arm(8'd2);
      pass_cnt = 8'd0;
      pulse(3, 1'b0, 8'd0);
      pulse(3, 1'b0, 8'd0);
      chk("t3_no_halt_yet", 32'(halt_req), 0);
      chk("t3_hit_cnt_2", 32'(hit_cnt), 2);
      pulse(3, 1'b1, 8'd3);
      chk("t3_hit_cnt_3", 32'(hit_cnt), 3);
      do_disarm();
      chk("t3_disarmed", 32'(armed), 0);

      // Static match counts once; arm while ARMED is ignored
      do_arm(8'd1);
      repeat (10) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("t4_static_no_halt", 32'(halt_req), 0);
      chk("t4_static_hit_cnt", 32'(hit_cnt), 1);
      chk("t4_static_armed", 32'(armed), 1);
      pass_cnt = 8'd5;
      arm      = 1'b1;
      step(1'b1, 1'b1);
      arm      = 1'b0;
      chk("t4_arm_ignored_hit", 32'(hit_cnt), 1);
      pulse(4, 1'b1, 8'd2);
      halt_ack = 1'b1;
      step(1'b1, 1'b1);
      halt_ack = 1'b0;
      chk("t4_ack_drops_req", 32'(halt_req), 0);
      do_disarm();

      // Ack with the match held: REARM, no retrigger until the match drops
      do_arm(8'd0);
      expect_halt(5, 2, 8'd1);
      repeat (5) step(1'b0, 1'b1);
      chk("t5_halted", 32'(halt_req), 1);
      halt_ack = 1'b1;
      step(1'b0, 1'b1);
      chk("t5_ack_drops_req", 32'(halt_req), 0);
      repeat (3) step(1'b0, 1'b1);
      chk("t5_rearm_no_halt", 32'(halt_req), 0);
      chk("t5_rearm_armed", 32'(armed), 1);
      chk("t5_rearm_hit_cnt", 32'(hit_cnt), 1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      halt_ack = 1'b0;
      chk("t5_rearmed_no_req", 32'(halt_req), 0);
      pulse(5, 1'b1, 8'd2);
      chk("t5_rehalt_hit_cnt", 32'(hit_cnt), 2);
      halt_ack = 1'b1;
      step(1'b1, 1'b1);
      halt_ack = 1'b0;
      do_disarm();

      // arm+disarm together stays IDLE and leaves hit_cnt alone
      pass_cnt = 8'd0;
      arm      = 1'b1;
      disarm   = 1'b1;
      step(1'b1, 1'b1);
      arm      = 1'b0;
      disarm   = 1'b0;
      chk("t6_arm_disarm_idle", 32'(armed), 0);
      chk("t6_arm_disarm_hit", 32'(hit_cnt), 2);
      pulse(6, 1'b0, 8'd0);
      chk("t6_idle_no_halt", 32'(halt_req), 0);

      // pass_cnt=255: halt on event 256, hit_cnt saturates at 255
      do_arm(8'd255);
      for (int i = 1; i <= 300; i++) begin
         pulse(7, (i == 256), 8'd255);
         if (i == 255) begin
            chk("t6_ev255_no_halt", 32'(halt_req), 0);
            chk("t6_ev255_hit_cnt", 32'(hit_cnt), 255);
         end
      end
      chk("t6_final_halt_req", 32'(halt_req), 1);
      chk("t6_final_hit_sat", 32'(hit_cnt), 255);

      repeat (3) step(1'b1, 1'b0);
      chk("sb_all_halts_seen", 32'(sb_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish, expected completion");
      $fatal(1);
   end

endmodule
